// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract controller using one 4-bit slice.
// Define NIBBLE_SERIAL_ADD_SAT_EN to saturate the sum on signed overflow.
module nibble_serial_add_ctrl #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       low;
  logic [1:0]       hi;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_fin;
  logic             c4;
  logic             ovf;
  logic             last;

  // Split at bit 3 so the carry into the nibble MSB is visible for overflow.
  always_comb begin
    nib_a = a_q[4*cnt_q +: 4];
    nib_b = b_q[4*cnt_q +: 4];
    low   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
    hi    = {1'b0, nib_a[3]} + {1'b0, nib_b[3]} + {1'b0, low[3]};
    c4    = hi[1];
    ovf   = low[3] ^ hi[1];
    last  = (cnt_q == CW'(NIBBLES - 1));
    sum_d = sum_q;
    sum_d[4*cnt_q +: 4] = {hi[0], low[2:0]};
    sum_fin = sum_d;
`ifdef NIBBLE_SERIAL_ADD_SAT_EN
    if (ovf) begin
      sum_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          carry_q <= c4;
          if (last) begin
            sum_q   <= sum_fin;
            cout_q  <= c4;
            ovf_q   <= ovf;
            zero_q  <= (sum_fin == '0);
            state_q <= DONE;
          end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule
